// File: rtl/ring_phase_checker_pkg.sv
// rtl/ring_phase_checker_pkg.sv - shared types, constants and word helpers for the ring phase checker
package ring_pkg;

    localparam int RING_MAX_W      = 32;
    localparam int IDX_MAX_W       = $clog2(RING_MAX_W);
    localparam int DEF_WIDTH       = 4;
    localparam int DEF_LOCK_COUNT  = 2;
    localparam int DEF_REV_W       = 8;

    typedef logic [RING_MAX_W-1:0] ring_word_t;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKING  = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_FAULT    = 2'd3
    } ring_state_t;

    function automatic logic onehot_f(ring_word_t w);
        return ($countones(w) == 1);
    endfunction

    // Rotate the low `width` bits by one; dir=1 moves bit i to i+1 with the MSB wrapping to bit 0.
    function automatic ring_word_t rot_f(ring_word_t w, logic dir, int width);
        ring_word_t mask;
        ring_word_t r;
        mask = (width >= RING_MAX_W) ? '1 : ((ring_word_t'(1) << width) - ring_word_t'(1));
        if (dir) begin
            r = (w << 1) | (w >> (width - 1));
        end else begin
            r = (w >> 1) | (w << (width - 1));
        end
        return r & mask;
    endfunction

    function automatic logic [IDX_MAX_W-1:0] enc_f(ring_word_t w);
        logic [IDX_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < RING_MAX_W; i++) begin
            if (w[i]) begin
                r = IDX_MAX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ring_phase_checker_onehot_encoder.sv
// rtl/ring_phase_checker_onehot_encoder.sv - combinational one-hot to binary index with validity flag
module onehot_encoder
    import ring_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0]         word,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     valid
);

    localparam int IDX_W = $clog2(WIDTH);

    ring_word_t w;

    assign w     = ring_word_t'(word);
    assign valid = onehot_f(w);
    // Multi-hot or zero words report index 0 rather than a priority pick.
    assign idx   = valid ? IDX_W'(enc_f(w)) : '0;

endmodule

// File: rtl/ring_phase_checker.sv
// rtl/ring_phase_checker.sv - validates one-hot ring rotation, tracks lock state and counts revolutions
module ring_phase_checker
    import ring_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int REV_W      = DEF_REV_W,
    parameter bit SHIFT_LEFT = 1'b1,
    parameter bit HOLD_OK    = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         ring_in,
    input  logic                     clr_err,
    output logic [$clog2(WIDTH)-1:0] phase_idx,
    output logic                     phase_valid,
    output logic                     locked,
    output logic                     rev_pulse,
    output logic [REV_W-1:0]         revs,
    output logic                     err,
    output logic                     err_sticky
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int CNT_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] LOCK_TGT = CNT_W'(LOCK_COUNT);

    ring_state_t        state, state_nx;
    logic [CNT_W-1:0]   lock_cnt, cnt_nx;
    logic [WIDTH-1:0]   smp;
    logic [IDX_W-1:0]   enc_idx;
    logic               onehot;
    logic               step_ok;
    logic               is_wrap;
    logic               fault;
    logic               rev_hit;
    ring_word_t         in_w, smp_w;

    onehot_encoder #(.WIDTH(WIDTH)) u_enc (
        .word  (ring_in),
        .idx   (enc_idx),
        .valid (onehot)
    );

    assign in_w    = ring_word_t'(ring_in);
    assign smp_w   = ring_word_t'(smp);
    assign step_ok = onehot && ((in_w == rot_f(smp_w, SHIFT_LEFT, WIDTH)) ||
                                (HOLD_OK && (in_w == smp_w)));
    // A wrap step always changes the hot bit, so it can never be mistaken for a hold.
    assign is_wrap = SHIFT_LEFT ? (smp[WIDTH-1] && ring_in[0]) : (smp[0] && ring_in[WIDTH-1]);
    assign rev_hit = (state == ST_LOCKED) && step_ok && is_wrap;
    assign locked  = (state == ST_LOCKED);

    always_comb begin
        state_nx = state;
        cnt_nx   = lock_cnt;
        fault    = 1'b0;
        case (state)
            ST_UNLOCKED: begin
                if (onehot) begin
                    state_nx = ST_LOCKING;
                    cnt_nx   = '0;
                end
            end
            ST_LOCKING: begin
                if (step_ok) begin
                    cnt_nx = lock_cnt + 1'b1;
                    if (cnt_nx == LOCK_TGT) begin
                        state_nx = ST_LOCKED;
                    end
                end else if (onehot) begin
                    cnt_nx = '0;
                end else begin
                    state_nx = ST_UNLOCKED;
                    cnt_nx   = '0;
                end
            end
            ST_LOCKED: begin
                if (!step_ok) begin
                    state_nx = ST_FAULT;
                    fault    = 1'b1;
                end
            end
            ST_FAULT: begin
                state_nx = ST_UNLOCKED;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = ST_UNLOCKED;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_UNLOCKED;
            lock_cnt    <= '0;
            smp         <= '0;
            phase_idx   <= '0;
            phase_valid <= 1'b0;
            rev_pulse   <= 1'b0;
            revs        <= '0;
            err         <= 1'b0;
            err_sticky  <= 1'b0;
        end else begin
            state       <= state_nx;
            lock_cnt    <= cnt_nx;
            smp         <= ring_in;
            phase_idx   <= enc_idx;
            phase_valid <= onehot;
            rev_pulse   <= rev_hit;
            err         <= fault;
            if (rev_hit) begin
                revs <= revs + 1'b1;
            end
            if (fault) begin
                err_sticky <= 1'b1;
            end else if (clr_err) begin
                err_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ring_phase_checker.sv
// tb/tb_ring_phase_checker.sv - randomized self-checking bench for ring_phase_checker
module tb_ring_phase_checker;

    localparam int W    = 4;
    localparam int LOCK = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] ring_in = 4'b0001;
    logic         clr_err = 1'b0;
    logic [1:0]   phase_idx;
    logic         phase_valid, locked, rev_pulse, err, err_sticky;
    logic [7:0]   revs;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: streak < 0 means not attempting a lock.
    int prev     = 0;
    int streak   = -1;
    bit m_locked = 0;
    bit m_fault  = 0;
    int e_idx = 0, e_valid = 0, e_rev = 0, e_revs = 0, e_err = 0, e_sticky = 0;
    bit chk_en = 0;
    int cur = 1;

    ring_phase_checker dut (
        .clk         (clk),
        .rst         (rst),
        .ring_in     (ring_in),
        .clr_err     (clr_err),
        .phase_idx   (phase_idx),
        .phase_valid (phase_valid),
        .locked      (locked),
        .rev_pulse   (rev_pulse),
        .revs        (revs),
        .err         (err),
        .err_sticky  (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int next_of(int w);
        return (w == (1 << (W - 1))) ? 1 : w * 2;
    endfunction

    task automatic model_edge(int in, bit r, bit c);
        bit oh;
        bit ok;
        oh = ($countones(in[W-1:0]) == 1);
        e_err = 0;
        e_rev = 0;
        if (r) begin
            prev = 0; streak = -1; m_locked = 0; m_fault = 0;
            e_idx = 0; e_valid = 0; e_revs = 0; e_sticky = 0;
            return;
        end
        ok = oh && (in == next_of(prev));
        e_valid = oh;
        e_idx = 0;
        if (oh) begin
            for (int i = 0; i < W; i++) if (in == (1 << i)) e_idx = i;
        end
        if (m_fault) begin
            m_fault = 0;
            streak = -1;
        end else if (m_locked) begin
            if (ok) begin
                if (prev == (1 << (W - 1)) && in == 1) begin
                    e_rev = 1;
                    e_revs = (e_revs + 1) % 256;
                end
            end else begin
                m_locked = 0;
                m_fault = 1;
                e_err = 1;
            end
        end else if (streak < 0) begin
            if (oh) streak = 0;
        end else if (ok) begin
            streak++;
            if (streak == LOCK) begin
                m_locked = 1;
                streak = -1;
            end
        end else begin
            streak = oh ? 0 : -1;
        end
        if (e_err) e_sticky = 1;
        else if (c) e_sticky = 0;
        prev = in;
    endtask

    task automatic drive(int w, bit r = 0, bit c = 0);
        ring_in = w[W-1:0];
        rst = r;
        clr_err = c;
        @(posedge clk);
        model_edge(w, r, c);
        chk_en = 1;
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("phase_idx", int'(phase_idx), e_idx);
            check("phase_valid", int'(phase_valid), e_valid);
            check("locked", int'(locked), int'(m_locked));
            check("rev_pulse", int'(rev_pulse), e_rev);
            check("revs", int'(revs), e_revs);
            check("err", int'(err), e_err);
            check("err_sticky", int'(err_sticky), e_sticky);
        end
    end

    initial begin
        int r;
        int nxt;
        @(negedge clk);
        repeat (3) drive(4'b0001, 1);
        check("lit_reset_revs", int'(revs), 0);
        check("lit_reset_sticky", int'(err_sticky), 0);

        drive(4'b0001); check("lit_locked_s1", int'(locked), 0);
        drive(4'b0010); check("lit_locked_s2", int'(locked), 0);
        drive(4'b0100); check("lit_locked_s3", int'(locked), 1);
        drive(4'b1000); check("lit_idx_s4", int'(phase_idx), 3);
        drive(4'b0001); check("lit_rev_pulse", int'(rev_pulse), 1);
        check("lit_revs_1", int'(revs), 1);
        drive(4'b0010); check("lit_rev_once", int'(rev_pulse), 0);

        drive(4'b0110);
        check("lit_err", int'(err), 1);
        check("lit_err_sticky", int'(err_sticky), 1);
        check("lit_unlock_on_err", int'(locked), 0);
        check("lit_bad_valid", int'(phase_valid), 0);
        check("lit_bad_idx", int'(phase_idx), 0);
        drive(4'b0001); drive(4'b0010); drive(4'b0100);
        check("lit_not_yet", int'(locked), 0);
        drive(4'b1000);
        check("lit_relock", int'(locked), 1);
        check("lit_sticky_held", int'(err_sticky), 1);

        drive(4'b0001); check("lit_revs_2", int'(revs), 2);
        drive(4'b0100);
        check("lit_skip_err", int'(err), 1);
        check("lit_skip_revs", int'(revs), 2);

        drive(4'b0001); drive(4'b0010); drive(4'b0100); drive(4'b1000);
        drive(4'b0001);
        drive(4'b0000, 0, 1);
        check("lit_set_priority", int'(err_sticky), 1);
        drive(4'b0000, 0, 1);
        check("lit_clr", int'(err_sticky), 0);

        drive(4'b0001, 1);
        drive(4'b0001); drive(4'b0010); drive(4'b0100); drive(4'b1000);
        for (int k = 0; k < 256; k++) begin
            drive(4'b0001); drive(4'b0010); drive(4'b0100); drive(4'b1000);
        end
        check("lit_revs_wrap", int'(revs), 0);
        drive(4'b0001); drive(4'b0010);
        check("lit_revs_after_wrap", int'(revs), 1);
        drive(4'b0010, 1);
        check("lit_rst_revs", int'(revs), 0);
        check("lit_rst_locked", int'(locked), 0);
        drive(4'b0100); drive(4'b1000);
        check("lit_rst_relock2", int'(locked), 0);
        drive(4'b0001);
        check("lit_rst_relock3", int'(locked), 1);

        cur = 1;
        for (int k = 0; k < 2000; k++) begin
            r = $urandom_range(0, 99);
            if ($countones(cur[W-1:0]) != 1) cur = 1;
            if (r < 70)      nxt = next_of(cur);
            else if (r < 78) nxt = cur;
            else if (r < 84) nxt = next_of(next_of(cur));
            else if (r < 92) nxt = $urandom_range(0, 15);
            else             nxt = 0;
            drive(nxt, ($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0));
            cur = nxt;
        end

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
